// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the byte-lane data memory.
//   - access size encodings carried on req_size
//   - FSM state type for dmem_bytelane
//   - wait-state counter width (LAT range 0..7)
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is reserved and behaves as a word

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_bytelane.
//   Store side: size/offset/wdata -> per-byte write mask + lane-shifted data.
//   Load side : raw word + size/offset/is_signed -> extended load result.
//   misalign  : half at odd offset or word at non-zero offset; only raised
//               when DMEM_MISALIGN_TRAP_EN is defined, otherwise the low
//               offset bits are forced to alignment and the access proceeds.
// Ports:
//   size, offset, is_signed     access descriptor
//   wdata      -> wmask, wdata_sh   store steering
//   rdata_raw  -> rdata_ext         load extraction / extension
//   misalign                        suppress flag (mask and result forced 0)
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]         size,
  input  logic [1:0]         offset,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH/8-1:0] wmask,
  output logic [WIDTH-1:0]   wdata_sh,
  input  logic [WIDTH-1:0]   rdata_raw,
  output logic [WIDTH-1:0]   rdata_ext,
  output logic               misalign
);

  localparam int unsigned NB = WIDTH / 8;

  logic [1:0]       off_eff;
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] rd_sh;

  always_comb begin
    misalign = 1'b0;
    off_eff  = offset;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (size)
      SZ_BYTE: begin end
      SZ_HALF: misalign = offset[0];
      default: misalign = (offset != 2'b00);
    endcase
`else
    case (size)
      SZ_BYTE: begin end
      SZ_HALF: off_eff[0] = 1'b0;
      default: off_eff    = 2'b00;
    endcase
`endif
  end

  assign sh_amt = {off_eff, 3'b000};

  always_comb begin
    wdata_sh = wdata << sh_amt;
    case (size)
      SZ_BYTE: wmask = NB'(1) << off_eff;
      SZ_HALF: wmask = NB'(3) << off_eff;
      default: wmask = '1;
    endcase
    if (misalign) wmask = '0;
  end

  always_comb begin
    rd_sh = rdata_raw >> sh_amt;
    case (size)
      SZ_BYTE: rdata_ext = {{(WIDTH-8){is_signed & rd_sh[7]}}, rd_sh[7:0]};
      SZ_HALF: rdata_ext = {{(WIDTH-16){is_signed & rd_sh[15]}}, rd_sh[15:0]};
      default: rdata_ext = rdata_raw;
    endcase
    if (misalign) rdata_ext = '0;
  end

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed data memory with valid/ready requests,
// LAT programmable wait states and a one-cycle response pulse.
// Optional macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses are suppressed
// and flagged on rsp_misalign; undefined -> addresses are force-aligned).
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready handshake; req_we, req_size, req_signed,
//   req_addr (byte address), req_wdata (right-justified store data)
//   rsp_valid pulse with rsp_rdata (extended load data) and rsp_misalign
//   test_value: lower half of word 0 (debug tap)
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_misalign,
  output logic [WIDTH/2-1:0] test_value
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / 8;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_misalign_q, rsp_misalign_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [AW-1:0]    idx;
  logic [NB-1:0]    wmask;
  logic [WIDTH-1:0] wdata_sh;
  logic [WIDTH-1:0] rdata_raw;
  logic [WIDTH-1:0] rdata_ext;
  logic             misalign;
  logic             accept;
  logic             addr_unused;

  // Upper address bits wrap modulo DEPTH words and are deliberately dropped.
  assign addr_unused = ^req_addr[WIDTH-1:AW+2];

  assign idx       = addr_q[AW+1:2];
  assign rdata_raw = mem_q[idx];
  assign req_ready = (state_q != WAIT);
  assign accept    = req_valid && req_ready;

  dmem_lane_align #(
    .WIDTH (WIDTH)
  ) u_lane (
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .is_signed (sgn_q),
    .wdata     (wdata_q),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_raw (rdata_raw),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    size_d         = size_q;
    sgn_d          = sgn_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mem_d          = mem_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = '0;
    rsp_misalign_d = 1'b0;

    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        // Commit edge: the write lands on the same edge rsp_valid rises.
        rsp_valid_d    = 1'b1;
        rsp_misalign_d = misalign;
        if (we_q) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (wmask[b]) mem_d[idx][8*b +: 8] = wdata_sh[8*b +: 8];
          end
        end else begin
          rsp_rdata_d = rdata_ext;
        end
        state_d = IDLE;
      end
      default: begin end
    endcase

    // A new request (IDLE or RESP) overrides the next-state choice above;
    // the commit in RESP still uses the previously latched request.
    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      sgn_d   = req_signed;
      addr_d  = req_addr[AW+1:0];
      wdata_d = req_wdata;
      if (LAT == 0) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_W'(LAT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      size_q         <= '0;
      sgn_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
      mem_q          <= '{default: '0};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      size_q         <= size_d;
      sgn_q          <= sgn_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_misalign_q <= rsp_misalign_d;
      mem_q          <= mem_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_misalign = rsp_misalign_q;
  assign test_value   = mem_q[0][WIDTH/2-1:0];

endmodule
